// File: rtl/aibnd_clkgate_pkg.sv
// Shared types and helpers for the aibnd multi-channel clock gate controller.
package aibnd_clkgate_pkg;

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StWake  = 2'd1,
    StOn    = 2'd2,
    StDrain = 2'd3
  } ch_state_e;

  // Hold counter must be able to hold the larger of the two dwell loads.
  function automatic int unsigned cnt_width(input int unsigned min_on,
                                            input int unsigned min_off);
    int unsigned m;
    m = (min_on > min_off) ? min_on : min_off;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/aibnd_clkgate_if.sv
// Request/acknowledge and gated-clock bundle between PM logic and the lane clock buffers.
interface aibnd_clkgate_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0] en_req;
  logic           force_on;
  logic [NCH-1:0] en_ack;
  logic [NCH-1:0] clkout;

  modport master (output en_req, output force_on, input en_ack, input clkout);
  modport slave  (input en_req, input force_on, output en_ack, output clkout);
endinterface

// File: rtl/aibnd_clkgate_ch.sv
// One gated-clock channel: request synchroniser, dwell FSM, hold counter and latch gate.
module aibnd_clkgate_ch
  import aibnd_clkgate_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned MinOn      = 4,
  parameter int unsigned MinOff     = 4,
  parameter bit          InvOut     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_req_i,
  input  logic force_on_i,
  output logic en_ack_o,
  output logic clkout_o
);

  localparam int unsigned CntW = cnt_width(MinOn, MinOff);

  logic [SyncStages-1:0] sync_q, sync_d;
  ch_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  gate_en_q, gate_en_d;
  logic                  ack_q, ack_d;
  logic                  s_req;
  logic                  gate_lat;
  logic                  gclk;

  assign s_req = sync_q[SyncStages-1];

  // Next-state, hold counter and registered gate/ack decode.
  always_comb begin
    sync_d  = {sync_q[SyncStages-2:0], en_req_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        if (s_req && (cnt_q == '0)) state_d = StWake;
      end
      StWake: begin
        state_d = StOn;
        cnt_d   = CntW'(MinOn - 1);
      end
      StOn: begin
        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
        if (!s_req && (cnt_q == '0)) state_d = StDrain;
      end
      StDrain: begin
        state_d = StOff;
        cnt_d   = CntW'(MinOff - 1);
      end
      default: state_d = StOff;
    endcase
    gate_en_d = (state_d == StWake) || (state_d == StOn);
    ack_d     = (state_d == StOn) || (state_d == StDrain);
  end

  // State, synchroniser and decoded outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= StOff;
      cnt_q     <= '0;
      gate_en_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gate_en_q <= gate_en_d;
      ack_q     <= ack_d;
    end
  end

  // ICG-style latch: open while clk is low so the gate only changes between pulses.
  always_latch begin
    if (rst) begin
      gate_lat = 1'b0;
    end else if (!clk) begin
      gate_lat = gate_en_q | force_on_i;
    end
  end

  assign gclk     = clk & gate_lat;
  assign clkout_o = InvOut ? ~gclk : gclk;
  assign en_ack_o = ack_q;

endmodule

// File: rtl/aibnd_clkgate_ctrl.sv
// Multi-channel glitch-free clock gate controller for the aibnd I/O clock tree.
module aibnd_clkgate_ctrl
  import aibnd_clkgate_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_ON      = 4,
  parameter int unsigned MIN_OFF     = 4,
  parameter bit          INV_OUT     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vccl_aibnd,
  input  logic          vssl_aibnd,
  aibnd_clkgate_if.slave bus
);

  // Supply pins carry no logic; they are only terminated here.
  logic unused_pwr;
  assign unused_pwr = vccl_aibnd ^ vssl_aibnd;

  // One independent channel per lane.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    aibnd_clkgate_ch #(
      .SyncStages (SYNC_STAGES),
      .MinOn      (MIN_ON),
      .MinOff     (MIN_OFF),
      .InvOut     (INV_OUT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_req_i   (bus.en_req[i]),
      .force_on_i (bus.force_on),
      .en_ack_o   (bus.en_ack[i]),
      .clkout_o   (bus.clkout[i])
    );
  end

endmodule
